mips_mem_responder: RTL and testbench

Memory-side responder for the multicycle MIPS core's memory port. It services the core's single shared instruction/data memory interface (`r_wbar` read/write select, byte address, write data) with a request/ready handshake and a fixed, parameterised number of wait states. It sits between the core's datapath and the word storage array, so the controller can be built and verified against realistic memory latency instead of an ideal zero-wait memory.

---
 rtl/mips_mem_pkg.sv | 17 +
 rtl/mips_mem_array.sv | 25 ++
 rtl/mips_mem_responder.sv | 123 ++++++++++++
 tb/tb_mips_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory responder.
// Optional misaligned-access flagging: MIPS_MEM_ALIGN_CHECK_EN.
package mips_mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/mips_mem_array.sv
// Word storage: synchronous write, combinational read.
// Contents are never reset.
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mips_mem_responder.sv
// Request/ready memory responder with fixed wait states.
// Define MIPS_MEM_ALIGN_CHECK_EN to flag misaligned accesses via err.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              r_wbar,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                  state_q;
    state_t                  state_d;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [1:0]              lo_q;
    logic                    rw_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       rdata_q;

    logic                    idle;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   cur_idx;
    logic [1:0]              cur_lo;
    logic                    cur_rw;
    logic                    mis;
    logic                    we;
    logic                    enter_resp;
    logic [DATA_W-1:0]       arr_rdata;
    logic                    unused_ok;

    assign idle   = (state_q == IDLE);
    assign accept = idle & req;

    // With zero wait states RESP is entered straight from IDLE,
    // so the live inputs must feed the array that cycle.
    assign cur_idx = idle ? addr[ADDR_WIDTH+1:2] : idx_q;
    assign cur_lo  = idle ? addr[1:0] : lo_q;
    assign cur_rw  = idle ? r_wbar : rw_q;

`ifdef MIPS_MEM_ALIGN_CHECK_EN
    assign mis = (cur_lo != 2'b00);
`else
    assign mis = 1'b0;
`endif

    assign unused_ok = ^{addr[ADDR_W-1:ADDR_WIDTH+2], cur_lo};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            lo_q    <= '0;
            rw_q    <= MEM_READ;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q   <= WAIT_INIT;
                idx_q   <= addr[ADDR_WIDTH+1:2];
                lo_q    <= addr[1:0];
                rw_q    <= r_wbar;
                wdata_q <= wdata;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (enter_resp && cur_rw == MEM_READ) begin
                rdata_q <= mis ? '0 : arr_rdata;
            end
        end
    end

    assign we = (state_q == RESP) && (rw_q == MEM_WRITE) && !mis;

    mips_mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .idx   (cur_idx),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    assign rdata = rdata_q;
    assign ready = (state_q == RESP);
    assign busy  = !idle;
    assign err   = (state_q == RESP) && mis;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder.
// Two instances: WAIT_CYCLES = 2 and WAIT_CYCLES = 0.
module tb_mips_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        req, r_wbar;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, busy, err;

    logic        req0, r_wbar0;
    logic [31:0] addr0, wdata0;
    logic [31:0] rdata0;
    logic        ready0, busy0, err0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_mem_responder #(
        .ADDR_WIDTH (10),
        .WAIT_CYCLES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .r_wbar(r_wbar),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .busy  (busy),
        .err   (err)
    );

    mips_mem_responder #(
        .ADDR_WIDTH (10),
        .WAIT_CYCLES(0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .req   (req0),
        .r_wbar(r_wbar0),
        .addr  (addr0),
        .wdata (wdata0),
        .rdata (rdata0),
        .ready (ready0),
        .busy  (busy0),
        .err   (err0)
    );

    // Drives one access and waits for ready; lat = 0 on timeout.
    task automatic access(input bit sel, input logic rw,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd,
                          output logic e, output int bc);
        lat = 0;
        bc  = 0;
        rd  = '0;
        e   = 1'b0;
        @(negedge clk);
        if (sel) begin
            req0 = 1'b1; r_wbar0 = rw; addr0 = a; wdata0 = d;
        end else begin
            req = 1'b1; r_wbar = rw; addr = a; wdata = d;
        end
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (sel ? busy0 : busy) bc++;
            if (sel ? ready0 : ready) begin
                lat = i;
                rd  = sel ? rdata0 : rdata;
                e   = sel ? err0 : err;
                break;
            end
        end
        if (sel) req0 = 1'b0;
        else     req  = 1'b0;
    endtask

    task automatic test_reset();
        int lat, bc;
        logic [31:0] rd;
        logic e;
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({ready, busy, err, rdata} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %h want 0",
                     {ready, busy, err, rdata});
        end
        @(negedge clk);
        reset = 1'b1;
        access(0, 1'b0, 32'h10, 32'hAAAA5555, lat, rd, e, bc);
        access(0, 1'b1, 32'h10, 32'h0, lat, rd, e, bc);
        n_cmp++;
        if (rd !== 32'hAAAA5555) begin
            n_err++;
            $display("FAIL pre_reset_read got %h want aaaa5555", rd);
        end
        @(negedge clk);
        req = 1'b1; r_wbar = 1'b0; addr = 32'h10; wdata = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_in_wait got %b want 1", busy);
        end
        reset = 1'b0;
        req   = 1'b0;
        #1;
        n_cmp++;
        if ({ready, busy, err, rdata} !== 35'd0) begin
            n_err++;
            $display("FAIL midop_reset got %h want 0",
                     {ready, busy, err, rdata});
        end
        @(negedge clk);
        reset = 1'b1;
        access(0, 1'b1, 32'h10, 32'h0, lat, rd, e, bc);
        n_cmp++;
        if (lat !== 3 || rd !== 32'hAAAA5555) begin
            n_err++;
            $display("FAIL after_reset lat %0d data %h want 3 aaaa5555",
                     lat, rd);
        end
    endtask

    task automatic test_write_read();
        int lat, bc;
        logic [31:0] rd;
        logic e;
        access(0, 1'b0, 32'h40, 32'hDEADBEEF, lat, rd, e, bc);
        n_cmp++;
        if (lat !== 3 || bc !== 3) begin
            n_err++;
            $display("FAIL write_timing lat %0d busy %0d want 3 3", lat, bc);
        end
        access(0, 1'b1, 32'h40, 32'h0, lat, rd, e, bc);
        n_cmp++;
        if (lat !== 3 || bc !== 3) begin
            n_err++;
            $display("FAIL read_timing lat %0d busy %0d want 3 3", lat, bc);
        end
        n_cmp++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
            n_err++;
            $display("FAIL read_data got %h err %b want deadbeef 0", rd, e);
        end
        @(negedge clk);
        n_cmp++;
        if (rdata !== 32'hDEADBEEF || ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rdata_hold got %h rdy %b busy %b want deadbeef 0 0",
                     rdata, ready, busy);
        end
    endtask

    task automatic test_zero_wait();
        int lat, bc;
        logic [31:0] rd;
        logic e;
        access(1, 1'b0, 32'h0, 32'hCAFEF00D, lat, rd, e, bc);
        n_cmp++;
        if (lat !== 1 || bc !== 1) begin
            n_err++;
            $display("FAIL zw_write lat %0d busy %0d want 1 1", lat, bc);
        end
        access(1, 1'b1, 32'h0, 32'h0, lat, rd, e, bc);
        n_cmp++;
        if (lat !== 1 || bc !== 1 || rd !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL zw_read lat %0d busy %0d data %h want 1 1 cafef00d",
                     lat, bc, rd);
        end
    endtask

    task automatic test_wrap();
        int lat, bc;
        logic [31:0] rd;
        logic e;
        access(0, 1'b0, 32'h1000, 32'h12345678, lat, rd, e, bc);
        access(0, 1'b1, 32'h0000, 32'h0, lat, rd, e, bc);
        n_cmp++;
        if (rd !== 32'h12345678) begin
            n_err++;
            $display("FAIL wrap got %h want 12345678", rd);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        int k;
        logic [31:0] rd;
        logic e;
        access(0, 1'b0, 32'h100, 32'hA0A0A0A0, lat, rd, e, bc);
        access(0, 1'b0, 32'h104, 32'hB1B1B1B1, lat, rd, e, bc);
        @(negedge clk);
        req = 1'b1; r_wbar = 1'b1; addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        addr = 32'h104;
        k = 1;
        while (!ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k !== 3 || rdata !== 32'hA0A0A0A0) begin
            n_err++;
            $display("FAIL b2b_first lat %0d data %h want 3 a0a0a0a0",
                     k, rdata);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle busy %b rdy %b want 0 0", busy, ready);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept busy %b want 1", busy);
        end
        k = 1;
        while (!ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k !== 3 || rdata !== 32'hB1B1B1B1) begin
            n_err++;
            $display("FAIL b2b_second lat %0d data %h want 3 b1b1b1b1",
                     k, rdata);
        end
        r_wbar = 1'b0; addr = 32'h200; wdata = 32'h5A5AC3C3;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ready && k < 20);
        n_cmp++;
        if (k !== 4) begin
            n_err++;
            $display("FAIL b2b_write lat %0d want 4", k);
        end
        r_wbar = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ready && k < 20);
        n_cmp++;
        if (k !== 4 || rdata !== 32'h5A5AC3C3) begin
            n_err++;
            $display("FAIL raw lat %0d data %h want 4 5a5ac3c3", k, rdata);
        end
        req = 1'b0;
    endtask

    task automatic test_misaligned();
        int lat, bc;
        logic [31:0] rd;
        logic e;
        access(0, 1'b1, 32'h42, 32'h0, lat, rd, e, bc);
`ifdef MIPS_MEM_ALIGN_CHECK_EN
        n_cmp++;
        if (lat !== 3 || e !== 1'b1 || rd !== 32'h0) begin
            n_err++;
            $display("FAIL misaligned lat %0d err %b data %h want 3 1 0",
                     lat, e, rd);
        end
`else
        n_cmp++;
        if (lat !== 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL misaligned lat %0d err %b data %h want 3 0 deadbeef",
                     lat, e, rd);
        end
`endif
    endtask

    initial begin
        req = 1'b0; r_wbar = 1'b1; addr = '0; wdata = '0;
        req0 = 1'b0; r_wbar0 = 1'b1; addr0 = '0; wdata0 = '0;
        test_reset();
        test_write_read();
        test_zero_wait();
        test_wrap();
        test_back_to_back();
        test_misaligned();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
